// File: rtl/id_pipe_pkg.sv
// Shared ID/EX pipeline definitions: payload width and field positions.
// Consumers slice id_ex with these constants rather than magic numbers.
package id_pipe_pkg;

    localparam int ID_EX_W = 230;

    localparam int RS_DATA_LSB  = 0;
    localparam int RS_DATA_MSB  = 31;
    localparam int RT_DATA_LSB  = 32;
    localparam int RT_DATA_MSB  = 63;
    localparam int RS_LSB       = 64;
    localparam int RS_MSB       = 68;
    localparam int RT_LSB       = 69;
    localparam int RT_MSB       = 73;
    localparam int RD_LSB       = 74;
    localparam int RD_MSB       = 78;
    localparam int ALU_CTRL_LSB = 79;
    localparam int ALU_CTRL_MSB = 84;
    localparam int BR_ADDR_LSB  = 85;
    localparam int BR_ADDR_MSB  = 116;
    localparam int MEM_CTRL_LSB = 117;
    localparam int MEM_CTRL_MSB = 120;
    localparam int WB_CTRL_LSB  = 121;
    localparam int WB_CTRL_MSB  = 124;
    localparam int LU_DATA_LSB  = 125;
    localparam int LU_DATA_MSB  = 156;
    localparam int PC_PLUS4_LSB = 157;
    localparam int PC_PLUS4_MSB = 188;
    localparam int SHAMT_LSB    = 189;
    localparam int SHAMT_MSB    = 193;
    localparam int IMM32_LSB    = 194;
    localparam int IMM32_MSB    = 225;
    localparam int BRANCH_LSB   = 226;
    localparam int BRANCH_MSB   = 227;
    localparam int REG_DST_LSB  = 228;
    localparam int REG_DST_MSB  = 229;

endpackage

// File: rtl/irq_ctx_stack.sv
// LIFO of saved ID/EX contexts for nested interrupts.
// Pop wins over push; sticky overflow/underflow flags clear only on reset.
module irq_ctx_stack
    import id_pipe_pkg::*;
#(
    parameter int PAYLOAD_W    = ID_EX_W,
    parameter int BACKUP_DEPTH = 4,
    parameter int DEPTH_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [PAYLOAD_W-1:0] push_data,
    output logic [PAYLOAD_W-1:0] top_data,
    output logic                 empty,
    output logic [DEPTH_W-1:0]   depth,
    output logic                 overflow,
    output logic                 underflow
);

    logic [PAYLOAD_W-1:0] mem [BACKUP_DEPTH];
    logic [DEPTH_W-1:0]   depth_q;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DEPTH_W'(BACKUP_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;
    assign depth   = depth_q;

    // Select the top occupied slot; zero when the stack is empty
    always_comb begin
        top_data = '0;
        for (int i = 0; i < BACKUP_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_data = mem[i];
            end
        end
    end

    // Slot storage: push writes the slot just above the current top
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BACKUP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BACKUP_DEPTH; i++) begin
                if (do_push && depth_q == DEPTH_W'(i)) begin
                    mem[i] <= push_data;
                end
            end
        end
    end

    // Occupancy counter and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_pop) begin
                depth_q <= depth_q - 1'b1;
            end else if (do_push) begin
                depth_q <= depth_q + 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
            if (push && !pop && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_ex_ctx_reg.sv
// ID/EX pipeline register with load-use detection, flush/hold and IRQ stack.
// Optional perf counters: define ID_EX_PERF_CNT_EN.
module id_ex_ctx_reg
    import id_pipe_pkg::*;
#(
    parameter int PAYLOAD_W    = ID_EX_W,
    parameter int BACKUP_DEPTH = 4,
    parameter int DEPTH_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic [4:0]           ex_rt,
    input  logic                 ex_memread,
    input  logic                 flush,
    input  logic                 hold,
    input  logic                 irq_backup,
    input  logic                 irq_recovery,
    output logic [PAYLOAD_W-1:0] id_ex,
    output logic                 id_ex_valid,
    output logic                 bubble,
    output logic [DEPTH_W-1:0]   ctx_depth,
    output logic                 ctx_overflow,
    output logic                 ctx_underflow,
    output logic [15:0]          bubble_cnt,
    output logic [15:0]          flush_cnt
);

    logic [PAYLOAD_W-1:0] top_data;
    logic                 empty;

    // Load-use hazard; a load into $0 never creates a dependency
    always_comb begin
        bubble = ex_memread && (ex_rt != 5'd0) &&
                 ((id_rs == ex_rt) || (id_rt == ex_rt));
    end

    irq_ctx_stack #(
        .PAYLOAD_W   (PAYLOAD_W),
        .BACKUP_DEPTH(BACKUP_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (irq_backup),
        .pop      (irq_recovery),
        .push_data(id_ex),
        .top_data (top_data),
        .empty    (empty),
        .depth    (ctx_depth),
        .overflow (ctx_overflow),
        .underflow(ctx_underflow)
    );

    // Pipeline register: recovery > hold > flush/bubble > load
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex       <= '0;
            id_ex_valid <= 1'b0;
        end else if (irq_recovery) begin
            id_ex       <= empty ? '0 : top_data;
            id_ex_valid <= !empty;
        end else if (hold) begin
            id_ex       <= id_ex;
            id_ex_valid <= id_ex_valid;
        end else if (flush || bubble) begin
            id_ex       <= '0;
            id_ex_valid <= 1'b0;
        end else begin
            id_ex       <= payload_in;
            id_ex_valid <= 1'b1;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic bub_evt;
    logic fl_evt;

    assign bub_evt = bubble && !hold && !irq_recovery;
    assign fl_evt  = flush && !bubble && !hold && !irq_recovery;

    // Saturating event counters; each cycle counts in at most one
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bub_evt && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
            if (fl_evt && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_ctx_reg.sv
// Directed bench for id_ex_ctx_reg: hazards, flush/hold, nested IRQ stack.
// Expected counter values track whether ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_ctx_reg;

    localparam int W = 230;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] payload_in;
    logic [4:0]   id_rs;
    logic [4:0]   id_rt;
    logic [4:0]   ex_rt;
    logic         ex_memread;
    logic         flush;
    logic         hold;
    logic         irq_backup;
    logic         irq_recovery;
    logic [W-1:0] id_ex;
    logic         id_ex_valid;
    logic         bubble;
    logic [2:0]   ctx_depth;
    logic         ctx_overflow;
    logic         ctx_underflow;
    logic [15:0]  bubble_cnt;
    logic [15:0]  flush_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic [W-1:0] pc;
    logic [W-1:0] pd;
    logic [W-1:0] zero_w;
    logic [15:0]  exp_bc;
    logic [15:0]  exp_fc;

    always #5 clk = ~clk;

    id_ex_ctx_reg dut (
        .clk          (clk),
        .reset        (reset),
        .payload_in   (payload_in),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_rt        (ex_rt),
        .ex_memread   (ex_memread),
        .flush        (flush),
        .hold         (hold),
        .irq_backup   (irq_backup),
        .irq_recovery (irq_recovery),
        .id_ex        (id_ex),
        .id_ex_valid  (id_ex_valid),
        .bubble       (bubble),
        .ctx_depth    (ctx_depth),
        .ctx_overflow (ctx_overflow),
        .ctx_underflow(ctx_underflow),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        hold         = 1'b0;
        irq_backup   = 1'b0;
        irq_recovery = 1'b0;
        ex_memread   = 1'b0;
        ex_rt        = 5'd0;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
    endtask

    initial begin
        pa     = {6'h11, {7{32'hAAAA_AAAA}}};
        pb     = {6'h22, {7{32'h1234_5678}}};
        pc     = {6'h33, {7{32'hC0DE_0000}}};
        pd     = {6'h3F, {7{32'hDEAD_BEEF}}};
        zero_w = '0;
        idle();
        payload_in = pd;
        reset = 1'b1;
        step();
        step();
        chk("rst_id_ex", id_ex, zero_w);
        chk("rst_valid", W'(id_ex_valid), W'(0));
        chk("rst_depth", W'(ctx_depth), W'(0));
        chk("rst_ovf", W'(ctx_overflow), W'(0));
        chk("rst_unf", W'(ctx_underflow), W'(0));
        chk("rst_bcnt", W'(bubble_cnt), W'(0));
        chk("rst_fcnt", W'(flush_cnt), W'(0));
        reset = 1'b0;

        // load-use on rs
        payload_in = pa;
        ex_memread = 1'b1;
        ex_rt = 5'd5;
        id_rs = 5'd5;
        id_rt = 5'd9;
        settle();
        chk("lu_bubble", W'(bubble), W'(1));
        step();
        chk("lu_id_ex", id_ex, zero_w);
        chk("lu_valid", W'(id_ex_valid), W'(0));

        // load to $0 never stalls
        ex_rt = 5'd0;
        id_rs = 5'd0;
        settle();
        chk("lu0_bubble", W'(bubble), W'(0));
        step();
        chk("lu0_id_ex", id_ex, pa);
        chk("lu0_valid", W'(id_ex_valid), W'(1));

        // load-use on rt, then non-load
        ex_rt = 5'd7;
        id_rs = 5'd1;
        id_rt = 5'd7;
        settle();
        chk("lurt_bubble", W'(bubble), W'(1));
        ex_memread = 1'b0;
        settle();
        chk("nold_bubble", W'(bubble), W'(0));
        idle();

        // flush under hold is frozen, then applies
        payload_in = {115{2'b10}};
        flush = 1'b1;
        hold = 1'b1;
        step();
        chk("fh_id_ex", id_ex, pa);
        chk("fh_valid", W'(id_ex_valid), W'(1));
        hold = 1'b0;
        step();
        chk("fl_id_ex", id_ex, zero_w);
        chk("fl_valid", W'(id_ex_valid), W'(0));
        flush = 1'b0;

        // nested IRQ
        payload_in = pa;
        step();
        irq_backup = 1'b1;
        payload_in = pb;
        step();
        payload_in = pc;
        step();
        chk("nest_depth2", W'(ctx_depth), W'(2));
        chk("nest_id_ex_c", id_ex, pc);
        irq_backup = 1'b0;
        irq_recovery = 1'b1;
        step();
        chk("nest_pop1", id_ex, pb);
        chk("nest_depth1", W'(ctx_depth), W'(1));
        step();
        chk("nest_pop2", id_ex, pa);
        chk("nest_depth0", W'(ctx_depth), W'(0));
        chk("nest_valid", W'(id_ex_valid), W'(1));
        irq_recovery = 1'b0;

        // overflow: id_ex=pa now; stack becomes pa,pb,pc,pd
        irq_backup = 1'b1;
        payload_in = pb;
        step();
        payload_in = pc;
        step();
        payload_in = pd;
        step();
        payload_in = pa;
        step();
        chk("ovf_depth4", W'(ctx_depth), W'(4));
        chk("ovf_flag0", W'(ctx_overflow), W'(0));
        payload_in = pb;
        step();
        chk("ovf_depth_sat", W'(ctx_depth), W'(4));
        chk("ovf_flag1", W'(ctx_overflow), W'(1));
        chk("ovf_id_ex", id_ex, pb);
        irq_backup = 1'b0;

        // pops; the first also has hold+flush which recovery overrides
        irq_recovery = 1'b1;
        hold = 1'b1;
        flush = 1'b1;
        step();
        chk("pop1", id_ex, pd);
        chk("pop1_depth", W'(ctx_depth), W'(3));
        hold = 1'b0;
        flush = 1'b0;
        step();
        chk("pop2", id_ex, pc);
        step();
        chk("pop3", id_ex, pb);
        step();
        chk("pop4", id_ex, pa);
        chk("pop4_depth", W'(ctx_depth), W'(0));
        chk("pop4_unf", W'(ctx_underflow), W'(0));
        step();
        chk("pop5_id_ex", id_ex, zero_w);
        chk("pop5_valid", W'(id_ex_valid), W'(0));
        chk("pop5_unf", W'(ctx_underflow), W'(1));
        chk("ovf_sticky", W'(ctx_overflow), W'(1));
        irq_recovery = 1'b0;

        // simultaneous push and pop at depth 1 with top=C
        payload_in = pc;
        step();
        irq_backup = 1'b1;
        payload_in = pa;
        step();
        chk("sim_pre_depth", W'(ctx_depth), W'(1));
        irq_recovery = 1'b1;
        step();
        chk("sim_id_ex", id_ex, pc);
        chk("sim_depth", W'(ctx_depth), W'(0));
        irq_recovery = 1'b0;

        // push still happens under hold
        hold = 1'b1;
        payload_in = pd;
        step();
        chk("hpush_depth", W'(ctx_depth), W'(1));
        chk("hpush_id_ex", id_ex, pc);
        hold = 1'b0;
        payload_in = pa;
        step();
        payload_in = pb;
        step();
        chk("pre_rst_depth", W'(ctx_depth), W'(3));
        irq_backup = 1'b0;

        // reset mid-interrupt
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_id_ex", id_ex, zero_w);
        chk("mrst_valid", W'(id_ex_valid), W'(0));
        chk("mrst_depth", W'(ctx_depth), W'(0));
        chk("mrst_ovf", W'(ctx_overflow), W'(0));
        chk("mrst_unf", W'(ctx_underflow), W'(0));
        irq_recovery = 1'b1;
        step();
        chk("mrst_pop_unf", W'(ctx_underflow), W'(1));
        chk("mrst_pop_id_ex", id_ex, zero_w);
        irq_recovery = 1'b0;

        // counters: 3 applied bubbles, 2 applied flushes
        payload_in = pd;
        ex_memread = 1'b1;
        ex_rt = 5'd3;
        id_rs = 5'd3;
        step();
        step();
        flush = 1'b1;
        step();
        id_rs = 5'd4;
        step();
        step();
        hold = 1'b1;
        step();
        hold = 1'b0;
        flush = 1'b0;
        id_rs = 5'd3;
        irq_recovery = 1'b1;
        step();
        idle();
`ifdef ID_EX_PERF_CNT_EN
        exp_bc = 16'd3;
        exp_fc = 16'd2;
`else
        exp_bc = 16'd0;
        exp_fc = 16'd0;
`endif
        chk("bubble_cnt", W'(bubble_cnt), W'(exp_bc));
        chk("flush_cnt", W'(flush_cnt), W'(exp_fc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
